uart_core_fifo: RTL
===================

# uart_core_fifo

Parametrised next-generation UART core: one transmitter and one receiver sharing a single 16x oversampling tick generator, with configurable frame format (data bits, parity, stop bits) and a FIFO on each direction. It replaces the fixed 8N1, unbuffered TX/RX pair at the top of the serial path. It adds parity and framing error detection and receive-overrun reporting. The host side uses a ready/valid handshake on both directions.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate. Tick divisor DIV = round(CLK_FREQ / (16*BAUD_RATE)), minimum 1.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries per FIFO, power of 2, at least 2.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- tx_valid, input, 1: host offers tx_data.
- tx_data, input, DATA_BITS: byte to send.
- tx_ready, output, 1: TX FIFO not full. Write occurs when tx_valid && tx_ready.
- tx_busy, output, 1: TX FSM is not idle, or the TX FIFO is non-empty.
- tx_serial, output, 1: serial line out. Idle high.
- rx_serial, input, 1: asynchronous serial line in.
- rx_valid, output, 1: RX FIFO non-empty.
- rx_data, output, DATA_BITS: head entry, show-ahead.
- rx_frame_err, output, 1: head entry's stop bit sampled low.
- rx_parity_err, output, 1: head entry's parity mismatched.
- rx_ready, input, 1: pop head when rx_valid && rx_ready.
- rx_overrun, output, 1: one-cycle pulse when a completed frame is dropped because the RX FIFO is full.

## Operation
- Tick generator: counter 0..DIV-1. sample_tick is high for one clk when the count equals DIV-1. It is free-running after reset.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE with FIFO non-empty: pop the head, load the shift register, clear the tick counter, enter START.
  - Each bit lasts exactly 16 sample_ticks.
  - Data is sent LSB first.
  - PARITY is skipped when PARITY = 0. Odd parity makes the count of 1s in data+parity odd.
  - STOP lasts STOP_BITS × 16 ticks, then returns to IDLE, or goes directly to START if the FIFO is non-empty (back-to-back frames, no idle gap).
- RX path:
  - rx_serial passes through a 2-flop synchroniser.
  - FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a low synchronised level enters START and clears the tick counter.
  - START: sample at tick 7. If high, treat as a false start and return to IDLE.
  - All later bits are sampled at tick 7 of their bit period (mid-bit).
  - Only the first stop bit is checked. Low sets the frame error.
  - On completing the first stop sample, push {frame_err, parity_err, data} if the FIFO is not full; otherwise pulse rx_overrun and discard the frame.
  - Then return to IDLE immediately. A second stop bit is not waited for.
- FIFOs: a push when full is ignored. A pop when empty is ignored. A simultaneous push and pop when full is impossible on TX (tx_ready is low). On RX, the FIFO-full check uses the count before the pop, so that frame is dropped.
- When DATA_BITS < 9, unused data bits do not exist. Widths are exact.

## Timing
- Reset values: tx_serial = 1, tx_ready = 1, tx_busy = 0, rx_valid = 0, rx_data = 0, rx_frame_err = 0, rx_parity_err = 0, rx_overrun = 0. Both FIFOs are emptied, both FSMs go to IDLE, and the tick counter goes to 0.
- Reset mid-frame: tx_serial is high on the next clk. A partially received frame is discarded.
- TX latency: a push at cycle N into an empty, idle core drives tx_serial low at cycle N+2. The frame spans (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × 16 × DIV clk cycles.
- tx_ready deasserts in the cycle after the write that fills the FIFO.
- RX latency: rx_valid rises 1 clk after the first-stop-bit sample tick.
- rx_data and flags are stable while rx_valid && !rx_ready.

## Structure
- Package uart_pkg holds: the parity encoding constants, the FSM state enums (tx_state_t, rx_state_t), the function calc_div(CLK_FREQ, BAUD_RATE), and the constant OVERSAMPLE = 16.
- One sub-module, uart_sync_fifo (WIDTH, DEPTH): show-ahead, with full, empty and count outputs. It is instantiated twice: TX with WIDTH = DATA_BITS, RX with WIDTH = DATA_BITS + 2.
- The tick generator, TX FSM and RX FSM are inline in uart_core_fifo.

## Test plan
All scenarios use CLK_FREQ = 1_600_000 and BAUD_RATE = 10_000, giving DIV = 10 and 160 clk per bit.
- 8N1 loopback (tx_serial→rx_serial): push 0x55, 0xA3, 0x00, 0xFF back-to-back → the same four bytes pop in order, with both error flags 0. There is no idle gap between the TX frames.
- 8E1: send 0x07 → the line carries parity bit 1. Inject a frame 0x07 with parity 0 → rx_parity_err = 1 and rx_data = 0x07.
- Framing: drive a frame 0x3C with a low stop bit → rx_frame_err = 1. The next valid frame 0x3C → rx_frame_err = 0.
- False start: a 40-clk low glitch on rx_serial → no push, and the FSM returns to IDLE.
- Overrun: FIFO_DEPTH = 4, rx_ready = 0, send 5 frames → rx_valid = 1 and count = 4, one rx_overrun pulse on the 5th frame, and the first 4 bytes are intact.
- Reset mid-TX: assert rst during the DATA bits → tx_serial = 1 on the next clk, tx_busy = 0, tx_ready = 1, and no further frame is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART core: parity encoding, FSM states,
// oversampling ratio and the tick divisor calculation.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // Rounded clk_freq / (16 * baud_rate), never below 1.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    int d;
    d = (clk_freq + (OVERSAMPLE * baud_rate) / 2) / (OVERSAMPLE * baud_rate);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO: dout presents the head entry whenever non-empty,
// and reads as zero when empty. Push-when-full and pop-when-empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_core_fifo.sv
// Buffered UART core: shared 16x tick generator, TX and RX FSMs with
// configurable frame format, and a FIFO in each direction.
//
// state  | meaning
// IDLE   | line idle (TX: waiting for FIFO data, RX: waiting for a low level)
// START  | start bit (RX checks for a false start at mid-bit)
// DATA   | data bits, LSB first
// PARITY | parity bit, skipped when parity is disabled
// STOP   | stop bit(s); RX leaves after sampling the first one
module uart_core_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_serial,
  input  logic                 rx_serial,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  input  logic                 rx_ready,
  output logic                 rx_overrun
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = $clog2(DATA_BITS);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(DATA_BITS - 1);
  localparam logic          HAS_PAR  = (PARITY != PARITY_NONE);
  localparam logic          PAR_ODD  = (PARITY == PARITY_ODD);

  logic [DW-1:0] div_cnt;
  logic          sample_tick;

  assign sample_tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || sample_tick) div_cnt <= '0;
    else                    div_cnt <= div_cnt + 1'b1;
  end

  // ---------------- TX ----------------
  tx_state_t            tx_state, tx_next;
  logic                 tx_pop, tx_full, tx_empty;
  logic [CW-1:0]        tx_count;
  logic [DATA_BITS-1:0] tx_head, tx_shift;
  logic [3:0]           tx_tick;
  logic [IW-1:0]        tx_idx;
  logic                 tx_stop_idx, tx_par, tx_bit_end, tx_stop_last;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_valid && !tx_full), .din(tx_data),
    .pop(tx_pop), .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  assign tx_ready     = !tx_full;
  assign tx_busy      = (tx_state != TX_IDLE) || (tx_count != '0);
  assign tx_bit_end   = sample_tick && (tx_tick == 4'd15);
  assign tx_stop_last = (STOP_BITS == 1) || tx_stop_idx;

  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      TX_IDLE:   if (!tx_empty) begin tx_next = TX_START; tx_pop = 1'b1; end
      TX_START:  if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:   if (tx_bit_end && tx_idx == BIT_LAST) tx_next = HAS_PAR ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
      TX_STOP: begin
        // Back-to-back frames: pop straight into the next start bit.
        if (tx_bit_end && tx_stop_last) begin
          if (!tx_empty) begin tx_next = TX_START; tx_pop = 1'b1; end
          else                 tx_next = TX_IDLE;
        end
      end
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_serial = 1'b1;
    case (tx_state)
      TX_START:  tx_serial = 1'b0;
      TX_DATA:   tx_serial = tx_shift[0];
      TX_PARITY: tx_serial = tx_par;
      default:   tx_serial = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_tick     <= '0;
      tx_idx      <= '0;
      tx_stop_idx <= 1'b0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
    end else if (tx_pop) begin
      tx_tick     <= '0;
      tx_idx      <= '0;
      tx_stop_idx <= 1'b0;
      tx_shift    <= tx_head;
      tx_par      <= (^tx_head) ^ PAR_ODD;
    end else if (sample_tick && tx_state != TX_IDLE) begin
      tx_tick <= tx_tick + 1'b1;
      if (tx_tick == 4'd15) begin
        if (tx_state == TX_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_idx   <= tx_idx + 1'b1;
        end
        if (tx_state == TX_STOP) tx_stop_idx <= ~tx_stop_idx;
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_t              rx_state, rx_next;
  logic                   rx_meta, rx_sync;
  logic [3:0]             rx_tick;
  logic [IW-1:0]          rx_idx;
  logic [DATA_BITS-1:0]   rx_shift;
  logic                   rx_par_bit, rx_par_err, rx_mid, rx_end, rx_done;
  logic                   rx_full, rx_empty;
  logic [CW-1:0]          rx_count;
  logic [DATA_BITS+1:0]   rx_head;

  assign rx_mid     = sample_tick && (rx_tick == 4'd7);
  assign rx_end     = sample_tick && (rx_tick == 4'd15);
  assign rx_par_err = HAS_PAR && (rx_par_bit != ((^rx_shift) ^ PAR_ODD));

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (!rx_sync) rx_next = RX_START;
      RX_START: begin
        if (rx_mid && rx_sync) rx_next = RX_IDLE;
        else if (rx_end)       rx_next = RX_DATA;
      end
      RX_DATA:   if (rx_end && rx_idx == BIT_LAST) rx_next = HAS_PAR ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_end) rx_next = RX_STOP;
      RX_STOP:   if (rx_mid) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_done = (rx_state == RX_STOP) && rx_mid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_tick    <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_par_bit <= 1'b0;
    end else if (rx_state == RX_IDLE) begin
      rx_tick <= '0;
      rx_idx  <= '0;
    end else if (sample_tick) begin
      rx_tick <= rx_tick + 1'b1;
      if (rx_mid && rx_state == RX_DATA)   rx_shift   <= {rx_sync, rx_shift[DATA_BITS-1:1]};
      if (rx_mid && rx_state == RX_PARITY) rx_par_bit <= rx_sync;
      if (rx_end && rx_state == RX_DATA)   rx_idx     <= rx_idx + 1'b1;
    end
  end

  // Full check uses the count before any same-cycle pop, so that frame is lost.
  always_ff @(posedge clk) begin
    if (rst) rx_overrun <= 1'b0;
    else     rx_overrun <= rx_done && rx_full;
  end

  uart_sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_done && !rx_full),
    .din({~rx_sync, rx_par_err, rx_shift}),
    .pop(rx_ready && !rx_empty), .dout(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign rx_valid      = (rx_count != '0);
  assign rx_data       = rx_head[DATA_BITS-1:0];
  assign rx_parity_err = rx_head[DATA_BITS];
  assign rx_frame_err  = rx_head[DATA_BITS+1];

endmodule
